// File: rtl/nmi_bus_arbiter_if.sv
// rtl/nmi_bus_arbiter_if.sv - requester-side and downstream NMI signal bundle for the arbiter
interface nmi_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    s_valid_i;
    logic [N_REQ*32-1:0] s_addr_i;
    logic [N_REQ*32-1:0] s_wdata_i;
    logic [N_REQ*4-1:0]  s_wstrb_i;
    logic [N_REQ-1:0]    s_ready_o;
    logic [31:0]         s_rdata_o;
    logic                m_valid_o;
    logic [31:0]         m_addr_o;
    logic [31:0]         m_wdata_o;
    logic [3:0]          m_wstrb_o;
    logic                m_ready_i;
    logic [31:0]         m_rdata_i;
    logic [N_REQ-1:0]    grant_o;
    logic                timeout_o;

    // Arbiter view: serves the requesters, drives the downstream port.
    modport slave (
        input  s_valid_i, s_addr_i, s_wdata_i, s_wstrb_i, m_ready_i, m_rdata_i,
        output s_ready_o, s_rdata_o, m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
        grant_o, timeout_o
    );

    // Environment view: requesters plus downstream target.
    modport master (
        output s_valid_i, s_addr_i, s_wdata_i, s_wstrb_i, m_ready_i, m_rdata_i,
        input  s_ready_o, s_rdata_o, m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
        grant_o, timeout_o
    );
endinterface

// File: rtl/nmi_bus_arbiter.sv
// rtl/nmi_bus_arbiter.sv - round-robin NMI arbiter with downstream stall watchdog
module nmi_bus_arbiter #(
    parameter int          N_REQ       = 4,
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    nmi_bus_arbiter_if.slave   bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q;
    logic [GW-1:0]    gnt_q;
    logic [GW-1:0]    last_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] grant_q;

    logic [GW-1:0]    pick;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] gnt_oh;
    logic             req_gnt;
    logic             in_grant;
    logic             done;
    logic             wd_fire;

    // Round-robin search starting just after the last requester served.
    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        pick    = last_q;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && bus.s_valid_i[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        pick_oh = '0;
        gnt_oh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pick_oh[k] = (pick == GW'(k));
            gnt_oh[k]  = (gnt_q == GW'(k));
        end
    end

    // Completion and watchdog qualifiers; reset forces every output quiet at once.
    always_comb begin
        in_grant = (state_q == GRANT) && !rst_i;
        req_gnt  = bus.s_valid_i[gnt_q];
        done     = in_grant && req_gnt && bus.m_ready_i;
        wd_fire  = WD_EN && in_grant && req_gnt && !bus.m_ready_i && (cnt_q == CNT_LAST);
    end

    // Downstream mux from the granted requester and response steering back to it.
    always_comb begin
        bus.m_valid_o = in_grant && req_gnt;
        bus.m_addr_o  = in_grant ? bus.s_addr_i[gnt_q*32 +: 32]  : 32'h0;
        bus.m_wdata_o = in_grant ? bus.s_wdata_i[gnt_q*32 +: 32] : 32'h0;
        bus.m_wstrb_o = in_grant ? bus.s_wstrb_i[gnt_q*4 +: 4]   : 4'h0;
        bus.s_ready_o = (done || wd_fire) ? gnt_oh : '0;
        bus.s_rdata_o = done ? bus.m_rdata_i : (wd_fire ? ERR_RDATA : 32'h0);
        bus.grant_o   = rst_i ? '0 : grant_q;
        bus.timeout_o = wd_fire;
    end

    // Arbitration FSM: one transaction in flight, IDLE cycle between grants.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(N_REQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.s_valid_i) begin
                        gnt_q   <= pick;
                        grant_q <= pick_oh;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_gnt) begin
                        // Requester abandoned its request: no completion, pointer unchanged.
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (bus.m_ready_i || wd_fire) begin
                        last_q  <= gnt_q;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nmi_bus_arbiter.sv
// tb/tb_nmi_bus_arbiter.sv - directed self-checking bench for nmi_bus_arbiter
module tb_nmi_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    nmi_bus_arbiter_if #(.N_REQ(4)) bus();

    nmi_bus_arbiter #(
        .N_REQ       (4),
        .TIMEOUT_CYC (16),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        bus.s_addr_i[k*32 +: 32]  = a;
        bus.s_wdata_i[k*32 +: 32] = wd;
        bus.s_wstrb_i[k*4 +: 4]   = ws;
    endtask

    logic [3:0]  order_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] order_ad [5] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300, 32'h1000_0000};
    logic [3:0]  order_ws [5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};

    initial begin
        rst           = 1'b1;
        bus.s_valid_i = 4'b1111;
        bus.m_ready_i = 1'b1;
        bus.m_rdata_i = 32'hABCD_0123;
        set_req(0, 32'h1000_0000, 32'hA000_0000, 4'h0);
        set_req(1, 32'h1000_0100, 32'hA000_0001, 4'hF);
        set_req(2, 32'h1000_0200, 32'hA000_0002, 4'h0);
        set_req(3, 32'h1000_0300, 32'hA000_0003, 4'hF);

        // Reset: all outputs quiet even with requests and downstream ready present.
        @(negedge clk); @(negedge clk); #1;
        check("rst_grant",   64'(bus.grant_o),   64'h0);
        check("rst_m_valid", 64'(bus.m_valid_o), 64'h0);
        check("rst_s_ready", 64'(bus.s_ready_o), 64'h0);
        check("rst_s_rdata", 64'(bus.s_rdata_o), 64'h0);
        check("rst_timeout", 64'(bus.timeout_o), 64'h0);
        @(negedge clk);
        rst           = 1'b0;
        bus.s_valid_i = 4'b0000;
        bus.m_ready_i = 1'b0;

        // Fair rotation with zero-wait downstream: 0,1,2,3,0, one completion every 2 cycles.
        @(negedge clk);
        bus.s_valid_i = 4'b1111;
        bus.m_ready_i = 1'b1;
        bus.m_rdata_i = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_idle_grant",   64'(bus.grant_o),   64'h0);
            check("rr_idle_s_ready", 64'(bus.s_ready_o), 64'h0);
            @(negedge clk); #1;
            check("rr_grant",   64'(bus.grant_o),   64'(order_oh[i]));
            check("rr_s_ready", 64'(bus.s_ready_o), 64'(order_oh[i]));
            check("rr_m_addr",  64'(bus.m_addr_o),  64'(order_ad[i]));
            check("rr_m_wstrb", 64'(bus.m_wstrb_o), 64'(order_ws[i]));
            check("rr_s_rdata", 64'(bus.s_rdata_o), 64'h0BAD_F00D);
            @(negedge clk);
        end
        bus.s_valid_i = 4'b0000;
        bus.m_ready_i = 1'b0;

        // Read with 3 wait states downstream.
        @(negedge clk);
        set_req(0, 32'h3000_0000, 32'h0, 4'h0);
        bus.s_valid_i = 4'b0001;
        #1;
        check("rd_c0_grant", 64'(bus.grant_o), 64'h0);
        @(negedge clk); #1;
        check("rd_c1_grant",   64'(bus.grant_o),   64'b0001);
        check("rd_c1_m_valid", 64'(bus.m_valid_o), 64'h1);
        check("rd_c1_m_addr",  64'(bus.m_addr_o),  64'h3000_0000);
        check("rd_c1_m_wstrb", 64'(bus.m_wstrb_o), 64'h0);
        check("rd_c1_s_ready", 64'(bus.s_ready_o), 64'h0);
        @(negedge clk); #1;
        check("rd_c2_s_ready", 64'(bus.s_ready_o), 64'h0);
        @(negedge clk); #1;
        check("rd_c3_s_ready", 64'(bus.s_ready_o), 64'h0);
        check("rd_c3_m_valid", 64'(bus.m_valid_o), 64'h1);
        @(negedge clk);
        bus.m_ready_i = 1'b1;
        bus.m_rdata_i = 32'h1234_5678;
        #1;
        check("rd_c4_s_ready", 64'(bus.s_ready_o), 64'b0001);
        check("rd_c4_s_rdata", 64'(bus.s_rdata_o), 64'h1234_5678);
        check("rd_c4_timeout", 64'(bus.timeout_o), 64'h0);
        @(negedge clk);
        bus.s_valid_i = 4'b0000;
        bus.m_ready_i = 1'b0;
        #1;
        check("rd_c5_grant", 64'(bus.grant_o), 64'h0);

        // Pointer skip: serve req1, then req1 and req2 together -> req2 first.
        @(negedge clk);
        bus.s_valid_i = 4'b0010;
        @(negedge clk); #1;
        check("skip_first_grant", 64'(bus.grant_o), 64'b0010);
        bus.m_ready_i = 1'b1;
        #1;
        check("skip_first_ready", 64'(bus.s_ready_o), 64'b0010);
        @(negedge clk);
        bus.m_ready_i = 1'b0;
        bus.s_valid_i = 4'b0110;
        #1;
        check("skip_idle_grant", 64'(bus.grant_o), 64'h0);
        @(negedge clk); #1;
        check("skip_grant", 64'(bus.grant_o), 64'b0100);
        bus.m_ready_i = 1'b1;
        #1;
        check("skip_ready", 64'(bus.s_ready_o), 64'b0100);
        @(negedge clk);
        bus.s_valid_i = 4'b0000;
        bus.m_ready_i = 1'b0;

        // Watchdog: req3 stalls, fires on the 16th GRANT cycle.
        @(negedge clk);
        bus.s_valid_i = 4'b1000;
        bus.m_rdata_i = 32'h7777_7777;
        for (int j = 1; j < 16; j++) begin
            @(negedge clk); #1;
            check("wd_wait", 64'({bus.timeout_o, bus.s_ready_o, bus.grant_o}), 64'({1'b0, 4'b0000, 4'b1000}));
        end
        @(negedge clk); #1;
        check("wd_s_ready", 64'(bus.s_ready_o), 64'b1000);
        check("wd_s_rdata", 64'(bus.s_rdata_o), 64'hDEAD_BEEF);
        check("wd_timeout", 64'(bus.timeout_o), 64'h1);
        @(negedge clk);
        bus.s_valid_i = 4'b0000;
        #1;
        check("wd_after_grant",   64'(bus.grant_o),   64'h0);
        check("wd_after_m_valid", 64'(bus.m_valid_o), 64'h0);
        check("wd_after_timeout", 64'(bus.timeout_o), 64'h0);

        // Race: m_ready_i on exactly the 16th GRANT cycle beats the watchdog.
        @(negedge clk);
        bus.s_valid_i = 4'b0001;
        for (int j = 1; j < 16; j++) begin
            @(negedge clk); #1;
            check("race_wait", 64'({bus.timeout_o, bus.s_ready_o, bus.grant_o}), 64'({1'b0, 4'b0000, 4'b0001}));
        end
        @(negedge clk);
        bus.m_ready_i = 1'b1;
        bus.m_rdata_i = 32'h5555_AAAA;
        #1;
        check("race_s_ready", 64'(bus.s_ready_o), 64'b0001);
        check("race_s_rdata", 64'(bus.s_rdata_o), 64'h5555_AAAA);
        check("race_timeout", 64'(bus.timeout_o), 64'h0);
        @(negedge clk);
        bus.s_valid_i = 4'b0000;
        bus.m_ready_i = 1'b0;

        // Reset in the middle of a req2 grant; afterwards req0 wins.
        @(negedge clk);
        bus.s_valid_i = 4'b0100;
        @(negedge clk); #1;
        check("rmid_grant", 64'(bus.grant_o), 64'b0100);
        rst           = 1'b1;
        bus.s_valid_i = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid_after_grant",   64'(bus.grant_o),   64'h0);
        check("rmid_after_m_valid", 64'(bus.m_valid_o), 64'h0);
        check("rmid_after_s_ready", 64'(bus.s_ready_o), 64'h0);
        check("rmid_after_timeout", 64'(bus.timeout_o), 64'h0);
        @(negedge clk); #1;
        check("rmid_first_winner", 64'(bus.grant_o), 64'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
